// File: rtl/syscall_controller.sv
// SYSCALL sequencer for the single-cycle MIPS core: services print_int, print_char,
// print_string (byte walk through data memory) and exit, streaming results to a console.
module syscall_controller #(
  parameter int MAX_STR_LEN = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              syscall,
  input  logic [31:0]       sys_call_reg,
  input  logic [31:0]       std_out_address,
  output logic              stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              out_is_int,
  input  logic              out_ready,
  output logic              halted,
  output logic              bad_syscall
);

  localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_EMIT, S_FETCH, S_CHAR, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_is_int_q, out_is_int_d;
  logic             is_str_q, is_str_d;
  logic             bad_q, bad_d;
  logic [7:0]       byte_q, byte_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             code_ok;
  logic [7:0]       rd_byte;

  assign code_ok = (sys_call_reg == 32'd1) || (sys_call_reg == 32'd4) ||
                   (sys_call_reg == 32'd10) || (sys_call_reg == 32'd11);

  // Memory words are big-endian: the lowest byte address is the MSB lane.
  always_comb begin
    case (ptr_q[1:0])
      2'd0:    rd_byte = mem_rd_data[31:24];
      2'd1:    rd_byte = mem_rd_data[23:16];
      2'd2:    rd_byte = mem_rd_data[15:8];
      default: rd_byte = mem_rd_data[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    out_data_d   = out_data_q;
    out_is_int_d = out_is_int_q;
    is_str_d     = is_str_q;
    byte_d       = byte_q;
    count_d      = count_q;
    bad_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (syscall) begin
          case (sys_call_reg)
            32'd1: begin
              out_data_d   = std_out_address;
              out_is_int_d = 1'b1;
              is_str_d     = 1'b0;
              state_d      = S_EMIT;
            end
            32'd11: begin
              out_data_d   = {24'b0, std_out_address[7:0]};
              out_is_int_d = 1'b0;
              is_str_d     = 1'b0;
              state_d      = S_EMIT;
            end
            32'd4: begin
              ptr_d    = std_out_address;
              count_d  = '0;
              is_str_d = 1'b1;
              state_d  = S_FETCH;
            end
            32'd10:  state_d = S_HALT;
            default: bad_d = 1'b1;
          endcase
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (is_str_q) begin
            ptr_d   = ptr_q + 32'd1;
            state_d = (count_q == CNT_W'(MAX_STR_LEN)) ? S_IDLE : S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FETCH: begin
        if (mem_rd_valid) begin
          byte_d  = rd_byte;
          state_d = S_CHAR;
        end
      end
      S_CHAR: begin
        if (byte_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          out_data_d   = {24'b0, byte_q};
          out_is_int_d = 1'b0;
          count_d      = count_q + 1'b1;
          state_d      = S_EMIT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      out_data_q   <= '0;
      out_is_int_q <= 1'b0;
      is_str_q     <= 1'b0;
      bad_q        <= 1'b0;
      byte_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      out_data_q   <= out_data_d;
      out_is_int_q <= out_is_int_d;
      is_str_q     <= is_str_d;
      bad_q        <= bad_d;
      byte_q       <= byte_d;
      count_q      <= count_d;
    end
  end

  // Outputs decode straight from state so a reset drops them without waiting for a clock.
  assign stall       = (state_q == S_IDLE) ? (syscall & code_ok) : 1'b1;
  assign mem_rd_en   = (state_q == S_FETCH);
  assign mem_addr    = {ptr_q[ADDR_W-1:2], 2'b00};
  assign out_valid   = (state_q == S_EMIT);
  assign out_data    = out_data_q;
  assign out_is_int  = out_is_int_q;
  assign halted      = (state_q == S_HALT);
  assign bad_syscall = bad_q;

endmodule

// File: tb/tb_syscall_controller.sv
// Directed bench for syscall_controller: vector table for single-shot services plus
// hand-written sequences for back-pressure, string walks, reset and halt.
module tb_syscall_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syscall;
  logic [31:0] sys_call_reg;
  logic [31:0] std_out_address;
  logic        stall;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_is_int;
  logic        out_ready;
  logic        halted;
  logic        bad_syscall;
  logic        mem_gate;

  int errors = 0;
  int checks = 0;

  logic [31:0] outq[$];
  bit          intq[$];
  logic [31:0] addrq[$];

  syscall_controller #(.MAX_STR_LEN(256), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .syscall(syscall), .sys_call_reg(sys_call_reg),
    .std_out_address(std_out_address), .stall(stall), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .out_valid(out_valid), .out_data(out_data), .out_is_int(out_is_int),
    .out_ready(out_ready), .halted(halted), .bad_syscall(bad_syscall)
  );

  always #5 clk = ~clk;

  // Zero-wait data memory: "Hi\0" near 0x10010000, 300 non-zero bytes at 0x20000000.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a == 32'h1001_0000) return 32'h0000_4869;
    if (a >= 32'h2000_0000 && a < 32'h2000_012C) return 32'h4142_4344;
    return 32'h0;
  endfunction

  assign mem_rd_data  = mem_read(mem_addr);
  assign mem_rd_valid = mem_rd_en & mem_gate;

  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      outq.push_back(out_data);
      intq.push_back(out_is_int);
    end
    if (mem_rd_en && mem_rd_valid) addrq.push_back(mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    outq.delete();
    intq.delete();
    addrq.delete();
  endtask

  // One-cycle syscall pulse, then count stalled cycles until the controller is idle again.
  task automatic run_sys(input logic [31:0] code, input logic [31:0] arg, input int budget,
                         output int scyc, output logic bad_seen);
    @(negedge clk);
    sys_call_reg    = code;
    std_out_address = arg;
    syscall         = 1'b1;
    #1 scyc = stall ? 1 : 0;
    @(negedge clk);
    syscall = 1'b0;
    #1 bad_seen = bad_syscall;
    while (stall && scyc < budget) begin
      scyc++;
      @(negedge clk);
      #1;
    end
    if (scyc >= budget) begin
      checks++;
      errors++;
      $display("FAIL timeout: stall still high after %0d cycles, required low", scyc);
    end
  endtask

  typedef struct {
    logic [31:0] code;
    logic [31:0] arg;
    logic [31:0] exp_data;
    logic        exp_int;
    int          exp_stall;
    logic        exp_bad;
    int          exp_nout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   scyc;
    logic bseen;
    int   bad_chars;
    logic [7:0] exp_c;

    vecs[0] = '{32'd1,  32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b1, 2, 1'b0, 1};
    vecs[1] = '{32'd1,  32'h0000_0000, 32'h0000_0000, 1'b1, 2, 1'b0, 1};
    vecs[2] = '{32'd1,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 2, 1'b0, 1};
    vecs[3] = '{32'd11, 32'h0000_0141, 32'h0000_0041, 1'b0, 2, 1'b0, 1};
    vecs[4] = '{32'd11, 32'hFFFF_FF7A, 32'h0000_007A, 1'b0, 2, 1'b0, 1};
    vecs[5] = '{32'd7,  32'h0000_0000, 32'h0,         1'b0, 0, 1'b1, 0};
    vecs[6] = '{32'd0,  32'h1234_5678, 32'h0,         1'b0, 0, 1'b1, 0};
    vecs[7] = '{32'd5,  32'h0000_0004, 32'h0,         1'b0, 0, 1'b1, 0};

    rst_n = 1'b0; syscall = 1'b0; sys_call_reg = '0; std_out_address = '0;
    out_ready = 1'b1; mem_gate = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_is_int", {31'b0, out_is_int}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_bad", {31'b0, bad_syscall}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      clear_q();
      run_sys(vecs[i].code, vecs[i].arg, 20, scyc, bseen);
      chk($sformatf("vec%0d_stall_cycles", i), scyc, vecs[i].exp_stall);
      chk($sformatf("vec%0d_bad", i), {31'b0, bseen}, {31'b0, vecs[i].exp_bad});
      chk($sformatf("vec%0d_nout", i), outq.size(), vecs[i].exp_nout);
      if (outq.size() > 0) begin
        chk($sformatf("vec%0d_data", i), outq[0], vecs[i].exp_data);
        chk($sformatf("vec%0d_is_int", i), {31'b0, intq[0]}, {31'b0, vecs[i].exp_int});
      end
      @(negedge clk);
      #1 chk($sformatf("vec%0d_bad_drop", i), {31'b0, bad_syscall}, 32'd0);
    end

    // print_char with the console back-pressured for 5 cycles.
    clear_q();
    out_ready = 1'b0;
    @(negedge clk);
    sys_call_reg = 32'd11; std_out_address = 32'h0000_0141; syscall = 1'b1;
    #1 chk("bp_decode_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    syscall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_valid%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_data%0d", i), out_data, 32'h41);
      chk($sformatf("bp_stall%0d", i), {31'b0, stall}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_stall", {31'b0, stall}, 32'd0);
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_nout", outq.size(), 32'd1);

    // print_string "Hi" starting mid-word.
    clear_q();
    run_sys(32'd4, 32'h1001_0002, 50, scyc, bseen);
    chk("hi_stall_cycles", scyc, 32'd9);
    chk("hi_nout", outq.size(), 32'd2);
    if (outq.size() == 2) begin
      chk("hi_char0", outq[0], 32'h48);
      chk("hi_char1", outq[1], 32'h69);
      chk("hi_char_not_int", {31'b0, intq[0] | intq[1]}, 32'd0);
    end
    chk("hi_nreads", addrq.size(), 32'd3);
    if (addrq.size() == 3) begin
      chk("hi_addr0", addrq[0], 32'h1001_0000);
      chk("hi_addr1", addrq[1], 32'h1001_0000);
      chk("hi_addr2", addrq[2], 32'h1001_0004);
    end

    // 300-byte unterminated string is cut at 256 characters.
    clear_q();
    run_sys(32'd4, 32'h2000_0000, 1200, scyc, bseen);
    chk("long_nout", outq.size(), 32'd256);
    chk("long_nreads", addrq.size(), 32'd256);
    bad_chars = 0;
    for (int i = 0; i < outq.size(); i++) begin
      exp_c = 8'h41 + 8'(i % 4);
      if (outq[i] !== {24'b0, exp_c}) bad_chars++;
    end
    chk("long_char_errors", bad_chars, 32'd0);
    chk("long_stall_low", {31'b0, stall}, 32'd0);

    // Reset while waiting on memory in FETCH.
    clear_q();
    mem_gate = 1'b0;
    @(negedge clk);
    sys_call_reg = 32'd4; std_out_address = 32'h1001_0000; syscall = 1'b1;
    @(negedge clk);
    syscall = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("fetch_rd_en", {31'b0, mem_rd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_gate = 1'b1;
    run_sys(32'd1, 32'h0000_1234, 20, scyc, bseen);
    chk("post_rst_stall_cycles", scyc, 32'd2);
    chk("post_rst_nout", outq.size(), 32'd1);
    if (outq.size() == 1) chk("post_rst_data", outq[0], 32'h0000_1234);

    // exit: halted and stall stick, later syscalls ignored, rst_n clears.
    clear_q();
    @(negedge clk);
    sys_call_reg = 32'd10; syscall = 1'b1;
    #1 chk("exit_decode_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    syscall = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_stall", {31'b0, stall}, 32'd1);
    sys_call_reg = 32'd1; std_out_address = 32'h55; syscall = 1'b1;
    @(negedge clk);
    syscall = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("halt_ignore_nout", outq.size(), 32'd0);
    chk("halt_still_halted", {31'b0, halted}, 32'd1);
    chk("halt_still_stall", {31'b0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", {31'b0, halted}, 32'd0);
    chk("halt_rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syscall_controller.md
Name: syscall_controller

Overview:
Sequences SYSCALL execution for the single-cycle MIPS core. On a decoded SYSCALL it samples the register-file outputs sys_call_reg ($v0) and std_out_address ($a0), stalls the core, and performs the service. Services are print integer, print string (byte walk through data memory), print char and exit. Results go to a console stream with a valid/ready handshake.

Parameters:
MAX_STR_LEN, 256, max characters emitted per print_string; the walk ends here even with no NUL
ADDR_W, 32, data-memory address width

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
syscall  input  1  high for the cycle the core decodes SYSCALL
sys_call_reg  input  32  $v0 from register file (service code)
std_out_address  input  32  $a0 from register file (argument/string address)
stall  output  1  freezes PC/writeback while high
mem_rd_en  output  1  data-memory read request
mem_addr  output  ADDR_W  word-aligned read address (bits[1:0]=0)
mem_rd_data  input  32  read word
mem_rd_valid  input  1  mem_rd_data valid, completes request
out_valid  output  1  console item valid
out_data  output  32  char in [7:0] (upper bits 0) or full integer
out_is_int  output  1  1: out_data is integer, 0: character
out_ready  input  1  console accepts item when out_valid&out_ready
halted  output  1  sticky after exit service
bad_syscall  output  1  one-cycle pulse on unsupported code

Behaviour:
- Reset (async, rst_n=0): state IDLE. stall, mem_rd_en, out_valid, out_is_int, halted and bad_syscall are 0. mem_addr, out_data and the char counter are 0.
- States: IDLE, EMIT, FETCH, CHAR, HALT.
- IDLE: on posedge with syscall=1, latch code=sys_call_reg and arg=std_out_address.
  - code 1 (print_int): out_data=arg, out_is_int=1 -> EMIT.
  - code 11 (print_char): out_data={24'b0,arg[7:0]}, out_is_int=0 -> EMIT.
  - code 4 (print_string): ptr=arg, count=0 -> FETCH.
  - code 10 (exit): -> HALT.
  - any other code: bad_syscall=1 for one cycle, stay IDLE, no stall.
- stall is combinational. It is 1 when (state==IDLE & syscall & code in {1,4,10,11}) or state!=IDLE. The core therefore holds SYSCALL until the controller returns to IDLE. The controller ignores syscall outside IDLE.
- EMIT: out_valid=1 and out_data stable until out_ready. On the handshake cycle: return to IDLE (int/char), or to FETCH with ptr+1 (string).
- FETCH: mem_rd_en=1, mem_addr={ptr[31:2],2'b00}, both held until mem_rd_valid. mem_rd_valid in the same cycle as the request counts. On valid, select byte big-endian: ptr[1:0]=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]. Register the byte -> CHAR.
- CHAR: byte==0 -> IDLE, nothing emitted. Otherwise out_data={24'b0,byte}, out_is_int=0, count+1 -> EMIT.
- Before FETCH, count==MAX_STR_LEN -> IDLE without reading.
- Every character issues its own word read; there is no word caching.
- ptr increments modulo 2^32 (wraps from 0xFFFFFFFF to 0).
- HALT: halted=1 and stall=1 permanently; only rst_n leaves HALT.
- Reset mid-operation: any state -> IDLE immediately. Partial strings are abandoned and out_valid drops asynchronously.
- Minimum latency: print_int/print_char stall 2 cycles with out_ready=1 (decode cycle + EMIT). Each string char costs FETCH + CHAR + EMIT, i.e. 3 cycles with zero-wait memory.

Test Plan:
- $v0=1, $a0=0xFFFFFFF6, syscall, out_ready=1 -> out_valid for 1 cycle with out_data=0xFFFFFFF6, out_is_int=1; stall high exactly 2 cycles.
- $v0=11, $a0=0x00000141, out_ready low 5 cycles -> out_data=0x41 held stable 5 cycles, stall held; released cycle after handshake.
- $v0=4, $a0=0x10010002, memory word 0x10010000=0x00004869, 0x10010004=0x00000000 -> emits 'H'(0x48), 'i'(0x69) in order; NUL at 0x10010004 ends walk; mem_addr values 0x10010000, 0x10010000, 0x10010004.
- $v0=4, string of 300 non-zero bytes, MAX_STR_LEN=256 -> exactly 256 chars emitted, then IDLE, stall low.
- $v0=10 -> halted=1 and stall=1 indefinitely; later syscalls ignored; rst_n pulse clears both.
- $v0=7 -> bad_syscall one cycle, stall never asserted. Separately, rst_n low during FETCH of a string -> mem_rd_en, out_valid, stall 0 immediately; next syscall serviced normally.
